contador_programa: RTL and testbench

//  Program counter register for the pipeline fetch stage: holds the current PC and

---
 rtl/contador_programa.sv | 118 +++++++++++
 tb/tb_contador_programa.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/contador_programa.sv
// Fetch-stage program counter: next-PC select (branch > jump > ret > pc_inc) with stall.
// Define CONTADOR_PROGRAMA_RAS_EN to add the circular return-address stack.
module contador_programa #(
   parameter int              PC_W      = 7,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int              RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic [PC_W-1:0] pc_inc,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            call,
   input  logic            ret,
   output logic [PC_W-1:0] pc,
   output logic            pc_valid,
   output logic            ras_empty,
   output logic            ras_err
);

   logic [PC_W-1:0] pc_next;

`ifdef CONTADOR_PROGRAMA_RAS_EN
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic [PC_W-1:0]  ras_mem_reg [RAS_DEPTH];
   logic [PTR_W-1:0] wp_reg;
   logic [PTR_W-1:0] top_idx;
   logic [CNT_W-1:0] cnt_reg;
   logic             ras_err_reg;
   logic             ras_full;
   logic             push;
   logic             pop;
   logic             err_next;

   // wp_reg is the next free slot; the newest entry sits just below it.
   assign top_idx   = wp_reg - PTR_W'(1);
   assign ras_full  = (cnt_reg == CNT_W'(RAS_DEPTH));
   assign ras_empty = (cnt_reg == '0);
   assign ras_err   = ras_err_reg;

   always_comb begin
      pc_next  = pc_inc;
      push     = 1'b0;
      pop      = 1'b0;
      err_next = 1'b0;
      if (branch_taken) begin
         pc_next = branch_target;
      end else if (jump) begin
         pc_next = jump_target;
         push    = call;
         err_next = call && ras_full;
      end else if (ret) begin
         if (ras_empty) begin
            err_next = 1'b1;
         end else begin
            pc_next = ras_mem_reg[top_idx];
            pop     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_reg      <= '0;
         cnt_reg     <= '0;
         ras_err_reg <= 1'b0;
      end else if (!enable) begin
         ras_err_reg <= 1'b0;
      end else begin
         ras_err_reg <= err_next;
         if (push) begin
            // A push on a full stack overwrites the oldest slot; depth saturates.
            wp_reg <= wp_reg + PTR_W'(1);
            if (!ras_full)
               cnt_reg <= cnt_reg + CNT_W'(1);
         end else if (pop) begin
            wp_reg  <= top_idx;
            cnt_reg <= cnt_reg - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enable && push)
         ras_mem_reg[wp_reg] <= pc_inc;
   end
`else
   logic unused_ras;

   assign unused_ras = call ^ ret;
   assign ras_empty  = 1'b1;
   assign ras_err    = 1'b0;

   always_comb begin
      pc_next = pc_inc;
      if (branch_taken)
         pc_next = branch_target;
      else if (jump)
         pc_next = jump_target;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         pc_valid <= 1'b0;
      end else if (enable) begin
         pc       <= pc_next;
         pc_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_contador_programa.sv
// Directed bench for contador_programa; expectations follow CONTADOR_PROGRAMA_RAS_EN.
module tb_contador_programa;

`ifdef CONTADOR_PROGRAMA_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   typedef struct {
      string      tag;
      logic [6:0] pc;
      logic       valid;
      logic       empty;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [6:0] pc_inc;
   logic       branch_taken;
   logic [6:0] branch_target;
   logic       jump;
   logic [6:0] jump_target;
   logic       call;
   logic       ret;
   logic [6:0] pc;
   logic       pc_valid;
   logic       ras_empty;
   logic       ras_err;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   contador_programa #(.PC_W(7), .RESET_PC(7'h00), .RAS_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .enable(enable), .pc_inc(pc_inc),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .call(call), .ret(ret),
      .pc(pc), .pc_valid(pc_valid), .ras_empty(ras_empty), .ras_err(ras_err)
   );

   always #5 clk = ~clk;

   task automatic check(input exp_t e);
      vectors++;
      assert (pc === e.pc) else begin
         miscompares++;
         $error("FAIL %s pc got %h exp %h", e.tag, pc, e.pc);
      end
      assert (pc_valid === e.valid) else begin
         miscompares++;
         $error("FAIL %s pc_valid got %b exp %b", e.tag, pc_valid, e.valid);
      end
      assert (ras_empty === e.empty) else begin
         miscompares++;
         $error("FAIL %s ras_empty got %b exp %b", e.tag, ras_empty, e.empty);
      end
      assert (ras_err === e.err) else begin
         miscompares++;
         $error("FAIL %s ras_err got %b exp %b", e.tag, ras_err, e.err);
      end
      $display("%s: pc=%h valid=%b empty=%b err=%b", e.tag, pc, pc_valid, ras_empty, ras_err);
   endtask

   // Drive one cycle of inputs, queue its expectation, sample #1 after the edge.
   task automatic step(input string tag, input logic en, input logic [6:0] inc,
                       input logic br, input logic [6:0] bt,
                       input logic j, input logic [6:0] jt,
                       input logic c, input logic r,
                       input logic [6:0] epc, input logic ev,
                       input logic ee, input logic eerr);
      exp_t e;
      enable = en; pc_inc = inc; branch_taken = br; branch_target = bt;
      jump = j; jump_target = jt; call = c; ret = r;
      e.tag = tag; e.pc = epc; e.valid = ev; e.empty = ee; e.err = eerr;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         miscompares++;
         $error("FAIL %s scoreboard empty got 0 exp 1", tag);
      end else begin
         check(sb_q.pop_front());
      end
   endtask

   task automatic check_now(input string tag, input logic [6:0] epc, input logic ev,
                            input logic ee, input logic eerr);
      exp_t e;
      e.tag = tag; e.pc = epc; e.valid = ev; e.empty = ee; e.err = eerr;
      check(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout got running exp finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; enable = 1'b0; pc_inc = '0; branch_taken = 1'b0; branch_target = '0;
      jump = 1'b0; jump_target = '0; call = 1'b0; ret = 1'b0;
      #1;
      check_now("reset", 7'h00, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      step("first_adv", 1, 7'h01, 0, 7'h00, 0, 7'h00, 0, 0, 7'h01, 1, 1, 0);
      step("jump_23",   1, 7'h02, 0, 7'h00, 1, 7'h23, 0, 0, 7'h23, 1, 1, 0);
      #2 rst = 1'b1;
      #1 check_now("async_rst", 7'h00, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step("post_rst",  1, 7'h01, 0, 7'h00, 0, 7'h00, 0, 0, 7'h01, 1, 1, 0);
      step("jump_7f",   1, 7'h02, 0, 7'h00, 1, 7'h7F, 0, 0, 7'h7F, 1, 1, 0);
      step("wrap",      1, 7'h00, 0, 7'h00, 0, 7'h00, 0, 0, 7'h00, 1, 1, 0);
      step("stall1",    0, 7'h11, 0, 7'h00, 0, 7'h00, 0, 0, 7'h00, 1, 1, 0);
      step("stall2",    0, 7'h22, 0, 7'h00, 1, 7'h05, 0, 0, 7'h00, 1, 1, 0);
      step("stall3",    0, 7'h33, 1, 7'h66, 0, 7'h00, 0, 0, 7'h00, 1, 1, 0);
      step("br_vs_jmp", 1, 7'h01, 1, 7'h40, 1, 7'h10, 1, 0, 7'h40, 1, 1, 0);
      step("br_stall",  0, 7'h41, 1, 7'h2A, 0, 7'h00, 0, 0, 7'h40, 1, 1, 0);
      step("ret_empty", 1, 7'h09, 0, 7'h00, 0, 7'h00, 0, 1, 7'h09, 1, 1, RAS_ON);
      step("seq_0a",    1, 7'h0A, 0, 7'h00, 0, 7'h00, 0, 0, 7'h0A, 1, 1, 0);
      step("jmp_ret",   1, 7'h0B, 0, 7'h00, 1, 7'h55, 0, 1, 7'h55, 1, 1, 0);
      step("branch_12", 1, 7'h56, 1, 7'h12, 0, 7'h00, 0, 0, 7'h12, 1, 1, 0);

      step("jump_05",   1, 7'h13, 0, 7'h00, 1, 7'h05, 0, 0, 7'h05, 1, 1, 0);
      step("call_30",   1, 7'h06, 0, 7'h00, 1, 7'h30, 1, 0, 7'h30, 1, !RAS_ON, 0);
      step("call_nojmp",1, 7'h31, 0, 7'h00, 0, 7'h00, 1, 0, 7'h31, 1, !RAS_ON, 0);
      step("ret_06",    1, 7'h32, 0, 7'h00, 0, 7'h00, 0, 1,
           RAS_ON ? 7'h06 : 7'h32, 1, 1, 0);
      for (int k = 0; k < 5; k++)
         step($sformatf("call%0d", k), 1, 7'(7'h60 + k), 0, 7'h00, 1, 7'(7'h10 + k), 1, 0,
              7'(7'h10 + k), 1, !RAS_ON, RAS_ON && (k == 4));
      step("stall_ret", 0, 7'h50, 0, 7'h00, 0, 7'h00, 0, 1, 7'h14, 1, !RAS_ON, 0);
      for (int k = 0; k < 4; k++)
         step($sformatf("ret%0d", k), 1, 7'h70, 0, 7'h00, 0, 7'h00, 0, 1,
              RAS_ON ? 7'(7'h64 - k) : 7'h70, 1, RAS_ON ? (k == 3) : 1'b1, 0);
      step("ret_under", 1, 7'h75, 0, 7'h00, 0, 7'h00, 0, 1, 7'h75, 1, 1, RAS_ON);
      step("seq_76",    1, 7'h76, 0, 7'h00, 0, 7'h00, 0, 0, 7'h76, 1, 1, 0);
      step("call_ret",  1, 7'h77, 0, 7'h00, 1, 7'h20, 1, 1, 7'h20, 1, !RAS_ON, 0);
      step("ret_77",    1, 7'h21, 0, 7'h00, 0, 7'h00, 0, 1,
           RAS_ON ? 7'h77 : 7'h21, 1, 1, 0);
      step("br_call",   1, 7'h78, 1, 7'h44, 1, 7'h3C, 1, 0, 7'h44, 1, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
